// File: rtl/mips_prog_loader.sv
// Boot-time program loader for the MIPS_32 core.
// Assembles a big-endian byte stream into 32-bit instruction words,
// writes them to consecutive instruction-memory addresses while the core
// is held halted, and releases the core once the HLT word has been stored.
module mips_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] HLT_WORD  = 32'hfc000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_halt,
  output logic              core_start,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] MaxCount = (ADDR_W+1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_ERR
  } state_t;

  state_t              state_q;
  logic [1:0]          byteCnt_q;
  logic [23:0]         partial_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                memWe_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [31:0]         memWdata_q;
  logic                coreHalt_q;
  logic                coreStart_q;
  logic                done_q;
  logic                errOverflow_q;
  logic [ADDR_W:0]     wordCount_q;

  logic                byteFire;
  logic [31:0]         assembled_d;
  logic [ADDR_W:0]     wordCount_d;

  // Bytes are only taken while collecting a word; WRITE, RUN and ERR stall the stream.
  assign s_ready = (state_q == ST_LOAD);

  assign mem_we       = memWe_q;
  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign core_halt    = coreHalt_q;
  assign core_start   = coreStart_q;
  assign done         = done_q;
  assign err_overflow = errOverflow_q;
  assign word_count   = wordCount_q;

  // Handshake detection, the word formed by the incoming byte, and the post-write count.
  always_comb begin
    byteFire    = s_valid && s_ready;
    assembled_d = {partial_q, s_data};
    wordCount_d = wordCount_q + 1'b1;
  end

  // Loader FSM: collects four bytes, issues one write cycle, then decides between
  // loading more, releasing the core (HLT) or stopping on capacity overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      byteCnt_q     <= 2'd0;
      partial_q     <= 24'd0;
      addr_q        <= '0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= 32'd0;
      coreHalt_q    <= 1'b1;
      coreStart_q   <= 1'b0;
      done_q        <= 1'b0;
      errOverflow_q <= 1'b0;
      wordCount_q   <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (byteFire) begin
            partial_q <= assembled_d[23:0];
            if (byteCnt_q == 2'd3) begin
              byteCnt_q  <= 2'd0;
              memWe_q    <= 1'b1;
              memAddr_q  <= addr_q;
              memWdata_q <= assembled_d;
              state_q    <= ST_WRITE;
            end else begin
              byteCnt_q <= byteCnt_q + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          memWe_q     <= 1'b0;
          wordCount_q <= wordCount_d;
          addr_q      <= addr_q + 1'b1;
          if (memWdata_q == HLT_WORD) begin
            coreHalt_q  <= 1'b0;
            done_q      <= 1'b1;
            coreStart_q <= 1'b1;
            state_q     <= ST_RUN;
          end else if (wordCount_d == MaxCount) begin
            errOverflow_q <= 1'b1;
            state_q       <= ST_ERR;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_RUN, ST_ERR: begin
          coreStart_q <= 1'b0;
          if (reload) begin
            state_q       <= ST_LOAD;
            byteCnt_q     <= 2'd0;
            addr_q        <= '0;
            coreHalt_q    <= 1'b1;
            done_q        <= 1'b0;
            errOverflow_q <= 1'b0;
            wordCount_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader (MAX_WORDS reduced to 4).
// Expected writes come from a program-level model: split the byte stream into
// big-endian words, stop after the first HLT word or after the capacity is hit.
module tb_mips_prog_loader;

  localparam int          AddrW = 10;
  localparam int          MaxW  = 4;
  localparam logic [31:0] Hlt   = 32'hfc000000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_ready;
  logic             reload = 1'b0;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             core_halt;
  logic             core_start;
  logic             done;
  logic             err_overflow;
  logic [AddrW:0]   word_count;

  mips_prog_loader #(.ADDR_W(AddrW), .MAX_WORDS(MaxW), .HLT_WORD(Hlt)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_halt(core_halt), .core_start(core_start), .done(done),
    .err_overflow(err_overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    int           nBytes;
    logic [127:0] stream;
    int           expCount;
    bit           expDone;
    bit           expErr;
  } vec_t;

  vec_t             vecs[5];
  int               checks = 0;
  int               errors = 0;
  int               cycleCnt = 0;
  int               lastAccept = -100;
  int               lastWriteCycle = -100;
  int               startCount = 0;
  logic [AddrW-1:0] logAddr[$];
  logic [31:0]      logData[$];
  logic [7:0]       stimBytes[$];
  logic [31:0]      expWords[$];
  bit               expRun;
  bit               expErr;
  int               sendLen;
  bit               prevStopped = 1'b0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write and start-pulse monitor, including latency and stall checks.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      logAddr.push_back(mem_addr);
      logData.push_back(mem_wdata);
      checkOutput("readyDuringWrite", 64'(s_ready), 64'(0));
      checkOutput("writeLatency", 64'(cycleCnt), 64'(lastAccept));
      lastWriteCycle = cycleCnt;
    end
    if (!rst && core_start) begin
      startCount++;
      checkOutput("startLatency", 64'(cycleCnt), 64'(lastWriteCycle + 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Presents one byte and waits (bounded) for it to be accepted; tries = cycles used, 0 on timeout.
  task automatic sendByte(input logic [7:0] b, input int gap, output int tries);
    bit ok;
    ok = 1'b0;
    tries = 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      tries = i + 1;
    end
    if (ok) lastAccept = cycleCnt;
    else begin
      tries = 0;
      checkOutput("byteTimeout", 64'(0), 64'(1));
    end
  endtask

  // Program-level reference: words in order, ending at HLT or at capacity.
  task automatic buildModel();
    logic [31:0] w;
    expWords.delete();
    expRun = 1'b0;
    expErr = 1'b0;
    for (int k = 0; k < stimBytes.size() / 4 && !expRun && !expErr; k++) begin
      w = {stimBytes[4*k], stimBytes[4*k+1], stimBytes[4*k+2], stimBytes[4*k+3]};
      expWords.push_back(w);
      if (w == Hlt) expRun = 1'b1;
      else if (expWords.size() == MaxW) expErr = 1'b1;
    end
    sendLen = (expRun || expErr) ? 4 * expWords.size() : stimBytes.size();
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clearLogs();
    logAddr.delete();
    logData.delete();
    startCount = 0;
  endtask

  task automatic sendRange(input int first, input int last, input bit randGap, input bit checkStall);
    int gap;
    int tries;
    for (int i = first; i < last; i++) begin
      gap = randGap ? $urandom_range(0, 2) : 0;
      sendByte(stimBytes[i], gap, tries);
      if (checkStall && gap == 0 && i > 0 && (i % 4) == 0)
        checkOutput($sformatf("stallAfterWrite[%0d]", i), 64'(tries), 64'(2));
    end
    s_valid = 1'b0;
  endtask

  // Restarts via reset or reload pulse, then streams the modelled bytes.
  task automatic applyStimulus(input string tag, input bit useReset, input bit randGap, input bit checkStall);
    if (useReset || !prevStopped) begin
      doReset();
    end else begin
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      checkOutput({tag, " reloadHalt"}, 64'(core_halt), 64'(1));
      checkOutput({tag, " reloadDone"}, 64'(done), 64'(0));
      checkOutput({tag, " reloadCount"}, 64'(word_count), 64'(0));
      checkOutput({tag, " reloadErr"}, 64'(err_overflow), 64'(0));
      checkOutput({tag, " reloadReady"}, 64'(s_ready), 64'(1));
    end
    clearLogs();
    buildModel();
    sendRange(0, sendLen, randGap, checkStall);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input string tag, input int expCount, input bit expDone, input bit expErrFlag);
    int n;
    checkOutput({tag, " nWrites"}, 64'(logData.size()), 64'(expWords.size()));
    n = (logData.size() < expWords.size()) ? logData.size() : expWords.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(logAddr[i]), 64'(i));
      checkOutput($sformatf("%s data[%0d]", tag, i), 64'(logData[i]), 64'(expWords[i]));
    end
    checkOutput({tag, " wordCount"}, 64'(word_count), 64'(expCount));
    checkOutput({tag, " done"}, 64'(done), 64'(expDone));
    checkOutput({tag, " errOverflow"}, 64'(err_overflow), 64'(expErrFlag));
    checkOutput({tag, " coreHalt"}, 64'(core_halt), 64'(!expDone));
    checkOutput({tag, " startPulses"}, 64'(startCount), 64'(expDone));
    checkOutput({tag, " sReady"}, 64'(s_ready), 64'(!expDone && !expErrFlag));
    if (expErrFlag) begin
      n = logData.size();
      s_valid = 1'b1;
      s_data  = 8'h5a;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checkOutput({tag, " errNoAccept"}, 64'(s_ready), 64'(0));
      end
      s_valid = 1'b0;
      checkOutput({tag, " errNoWrite"}, 64'(logData.size()), 64'(n));
    end
    prevStopped = expDone || expErrFlag;
  endtask

  task automatic loadVec(input int idx);
    stimBytes.delete();
    for (int i = 0; i < vecs[idx].nBytes; i++)
      stimBytes.push_back(vecs[idx].stream[127-8*i -: 8]);
  endtask

  initial begin
    int nw;
    logic [31:0] w;

    vecs[0] = '{"prog1", 12, {96'h2801000a_28020014_fc000000, 32'h0}, 3, 1'b1, 1'b0};
    vecs[1] = '{"prog2", 8, {64'h00222000_fc000000, 64'h0}, 2, 1'b1, 1'b0};
    vecs[2] = '{"overflow", 16, 128'h11111111_22222222_33333333_44444444, 4, 1'b0, 1'b1};
    vecs[3] = '{"hltAtCap", 16, 128'h01010101_02020202_03030303_fc000000, 4, 1'b1, 1'b0};
    vecs[4] = '{"loneHlt", 4, {32'hfc000000, 96'h0}, 1, 1'b1, 1'b0};

    // Reset state.
    #1;
    rst = 1'b1;
    #3;
    checkOutput("rst memWe", 64'(mem_we), 64'(0));
    checkOutput("rst memAddr", 64'(mem_addr), 64'(0));
    checkOutput("rst memWdata", 64'(mem_wdata), 64'(0));
    checkOutput("rst coreHalt", 64'(core_halt), 64'(1));
    checkOutput("rst coreStart", 64'(core_start), 64'(0));
    checkOutput("rst done", 64'(done), 64'(0));
    checkOutput("rst err", 64'(err_overflow), 64'(0));
    checkOutput("rst wordCount", 64'(word_count), 64'(0));
    checkOutput("rst sReady", 64'(s_ready), 64'(1));

    // Table vectors, back-to-back, chained by reload where the loader has stopped.
    for (int v = 0; v < 5; v++) begin
      loadVec(v);
      applyStimulus(vecs[v].name, v == 0, 1'b0, 1'b1);
      checkResult(vecs[v].name, vecs[v].expCount, vecs[v].expDone, vecs[v].expErr);
    end

    // Program 1 with idle gaps: stream content must be unchanged.
    loadVec(0);
    applyStimulus("prog1Gaps", 1'b1, 1'b1, 1'b0);
    checkResult("prog1Gaps", 3, 1'b1, 1'b0);

    // reload while loading is ignored and does not disturb a partial word.
    doReset();
    clearLogs();
    stimBytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hfc, 8'h00, 8'h00, 8'h00};
    buildModel();
    sendRange(0, 2, 1'b0, 1'b0);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    checkOutput("ignoredReload halt", 64'(core_halt), 64'(1));
    sendRange(2, 8, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkResult("ignoredReload", 2, 1'b1, 1'b0);

    // Asynchronous reset mid-word, with a handshake held across the reset edge.
    doReset();
    clearLogs();
    stimBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sendRange(0, 6, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h99;
    #1;
    checkOutput("asyncRst wordCount", 64'(word_count), 64'(0));
    checkOutput("asyncRst memWdata", 64'(mem_wdata), 64'(0));
    checkOutput("asyncRst memAddr", 64'(mem_addr), 64'(0));
    checkOutput("asyncRst coreHalt", 64'(core_halt), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_valid = 1'b0;
    clearLogs();
    stimBytes = '{8'h0c, 8'he7, 8'h78, 8'h00, 8'hfc, 8'h00, 8'h00, 8'h00};
    buildModel();
    sendRange(0, sendLen, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkResult("afterAsyncRst", 2, 1'b1, 1'b0);

    // Randomized programs against the program-level model.
    for (int t = 0; t < 30; t++) begin
      stimBytes.delete();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        w = ($urandom_range(0, 3) == 0) ? Hlt : 32'($urandom);
        for (int j = 3; j >= 0; j--) stimBytes.push_back(w[8*j +: 8]);
      end
      applyStimulus($sformatf("rand%0d", t), $urandom_range(0, 1) == 1, 1'b1, 1'b0);
      checkResult($sformatf("rand%0d", t), expWords.size(), expRun, expErr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
